// File: rtl/ifq_pkg.sv
// ifq_pkg: shared types for the instruction fetch queue.
// Provides the drain-state enum, queue entry struct and word-alignment helper.
package ifq_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [0:0] {
    IFQ_RUN   = 1'b0,
    IFQ_DRAIN = 1'b1
  } ifq_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ifq_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: DEPTH-entry circular buffer of fetched {pc, data} entries.
// Ports: clk, reset (sync, active-high), flush_i, push_i/wdata_i,
//        pop_i, rdata_o (head entry), count_o (occupancy).
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  ifq_entry_t               wdata_i,
  input  logic                     pop_i,
  output ifq_entry_t               rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  ifq_entry_t    mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;

  // Popping an empty buffer is a no-op.
  assign do_pop = pop_i && (cnt_q != '0);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (do_pop) rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; the count qualifies every read.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  // Upstream credit accounting must never let a push hit a full buffer.
  always_ff @(posedge clk) begin
    if (!reset && !flush_i && push_i && !do_pop) begin
      a_no_overflow: assert (cnt_q != FULL);
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch stage with credit-limited prefetch queue and redirect.
// Ports: clk, reset (sync, active-high); mem_req_* request channel;
//        mem_rsp_* in-order responses; instr_* decode handshake;
//        redirect_valid/redirect_pc flush and restart.
// Build option: define IFQ_BYPASS_EN for a same-cycle response-to-instr path
// when the queue is empty.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  ifq_state_e    state_q, state_d;

  logic [CW-1:0] count;
  logic [CW:0]   inflight;
  logic          q_empty;
  logic          req_hs;
  logic          accept;
  logic          byp;
  logic          push;
  logic          pop;
  ifq_entry_t    head;
  ifq_entry_t    wentry;

  assign q_empty  = (count == '0);
  assign inflight = {1'b0, count} + {1'b0, outst_q};

  // Queued plus in-flight words never exceed DEPTH, so a response
  // always finds a free slot.
  assign mem_req_valid = !reset && !redirect_valid && (inflight < LIMIT);
  assign mem_req_addr  = fetch_pc_q;
  assign req_hs        = mem_req_valid && mem_req_ready;

  // A response landing in a redirect cycle is stale and is discarded.
  assign accept = mem_rsp_valid && (state_q == IFQ_RUN) && !redirect_valid;

`ifdef IFQ_BYPASS_EN
  assign byp = accept && q_empty;
`else
  assign byp = 1'b0;
`endif

  assign push   = accept && !(byp && instr_ready);
  assign pop    = instr_ready && !q_empty && !redirect_valid;
  assign wentry = {rsp_pc_q, mem_rsp_data};

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CW'(req_hs) - CW'(mem_rsp_valid);
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      rsp_pc_d   = word_align(redirect_pc);
      // Every word still in flight belongs to the old stream.
      drop_d     = outst_q - CW'(mem_rsp_valid);
    end else begin
      if (req_hs) fetch_pc_d = fetch_pc_q + INSTR_BYTES;
      if (accept) rsp_pc_d = rsp_pc_q + INSTR_BYTES;
      if (mem_rsp_valid && state_q == IFQ_DRAIN) drop_d = drop_q - CW'(1);
    end
    state_d = (drop_d != '0) ? IFQ_DRAIN : IFQ_RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= word_align(RESET_PC);
      rsp_pc_q   <= word_align(RESET_PC);
      outst_q    <= '0;
      drop_q     <= '0;
      state_q    <= IFQ_RUN;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      state_q    <= state_d;
    end
  end

  // Outputs read as zero whenever nothing valid is presented.
  always_comb begin
    instr_valid = 1'b0;
    instr_data  = '0;
    instr_pc    = '0;
    if (byp) begin
      instr_valid = 1'b1;
      instr_data  = mem_rsp_data;
      instr_pc    = rsp_pc_q;
    end else if (!q_empty) begin
      instr_valid = 1'b1;
      instr_data  = head.data;
      instr_pc    = head.pc;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed bench for ifetch_queue with a fixed-latency
// in-order memory model; expectations hold with or without IFQ_BYPASS_EN.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  int errors = 0;
  int checks = 0;
  int mem_lat = 1;
  int cyc = 0;

`ifdef IFQ_BYPASS_EN
  localparam int L0 = 1;
`else
  localparam int L0 = 2;
`endif

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pq[$];
  logic [31:0] reqlog[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];

  ifetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hC001_D00D;
  endfunction

  // Memory model and consumer monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        pq.delete();
      end else if (mem_req_valid && mem_req_ready) begin
        pq.push_back('{mem_req_addr, cyc + mem_lat});
        reqlog.push_back(mem_req_addr);
      end
      if (!reset && instr_valid && instr_ready && !redirect_valid) begin
        got_pc.push_back(instr_pc);
        got_data.push_back(instr_data);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (pq.size() != 0 && pq[0].due <= cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = dat(pq[0].addr);
        void'(pq.pop_front());
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    mem_req_ready  = 1'b1;
    step();
    step();
    reset = 1'b0;
    reqlog.delete();
    got_pc.delete();
    got_data.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_req_valid: got %b want 0", mem_req_valid);
    end
    checks++;
    if (mem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_req_addr: got %h want 0", mem_req_addr);
    end
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_instr_valid: got %b want 0", instr_valid);
    end
    checks++;
    if (instr_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_instr_data: got %h want 0", instr_data);
    end
    checks++;
    if (instr_pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_instr_pc: got %h want 0", instr_pc);
    end
    mem_lat = 1;
    do_reset();
    @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL first_req: got %b/%h want 1/0", mem_req_valid, mem_req_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    mem_lat = 1;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'(4 * k)}) begin
        errors++;
        $display("FAIL stream_req[%0d]: got %b/%h want 1/%h",
                 k, mem_req_valid, mem_req_addr, 32'(4 * k));
      end
      if (k >= L0) begin
        e = 32'(4 * (k - L0));
        checks++;
        if ({instr_valid, instr_pc, instr_data} !== {1'b1, e, dat(e)}) begin
          errors++;
          $display("FAIL stream_instr[%0d]: got %b/%h/%h want 1/%h/%h",
                   k, instr_valid, instr_pc, instr_data, e, dat(e));
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    mem_lat = 1;
    do_reset();
    instr_ready = 1'b0;
    for (int k = 0; k < 10; k++) step();
    @(negedge clk);
    checks++;
    if (reqlog.size() != 4) begin
      errors++;
      $display("FAIL bp_req_count: got %0d want 4", reqlog.size());
    end
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_req_stall: got %b want 0", mem_req_valid);
    end
    checks++;
    if ({instr_valid, instr_pc} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL bp_head: got %b/%h want 1/0", instr_valid, instr_pc);
    end
    step();
    instr_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_full_cycle: got %b want 0", mem_req_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h10}) begin
      errors++;
      $display("FAIL bp_resume: got %b/%h want 1/00000010",
               mem_req_valid, mem_req_addr);
    end
    for (int k = 0; k < 6; k++) step();
    checks++;
    if (got_pc.size() < 5) begin
      errors++;
      $display("FAIL bp_pop_count: got %0d want >=5", got_pc.size());
    end
    for (int i = 0; i < 5; i++) begin
      if (i < got_pc.size()) begin
        checks++;
        if ({got_pc[i], got_data[i]} !== {32'(4 * i), dat(32'(4 * i))}) begin
          errors++;
          $display("FAIL bp_seq[%0d]: got %h/%h want %h/%h", i,
                   got_pc[i], got_data[i], 32'(4 * i), dat(32'(4 * i)));
        end
      end
    end
  endtask

  task automatic test_redirect_drain();
    mem_lat = 3;
    do_reset();
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_req_blocked: got %b want 0", mem_req_valid);
    end
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_instr_gap: got %b want 0", instr_valid);
    end
    checks++;
    if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h100}) begin
      errors++;
      $display("FAIL rd_new_req: got %b/%h want 1/00000100",
               mem_req_valid, mem_req_addr);
    end
    for (int k = 0; k < 12; k++) step();
    checks++;
    if (reqlog.size() < 4 || reqlog[3] !== 32'h100) begin
      errors++;
      $display("FAIL rd_reqlog: got %0d entries want 0x100 as 4th",
               reqlog.size());
    end
    checks++;
    if (got_pc.size() < 2) begin
      errors++;
      $display("FAIL rd_out_count: got %0d want >=2", got_pc.size());
    end else begin
      checks++;
      if ({got_pc[0], got_data[0]} !== {32'h100, dat(32'h100)}) begin
        errors++;
        $display("FAIL rd_first: got %h/%h want 00000100/%h",
                 got_pc[0], got_data[0], dat(32'h100));
      end
      checks++;
      if ({got_pc[1], got_data[1]} !== {32'h104, dat(32'h104)}) begin
        errors++;
        $display("FAIL rd_second: got %h/%h want 00000104/%h",
                 got_pc[1], got_data[1], dat(32'h104));
      end
    end
  endtask

  task automatic test_redirect_pop();
    int npre;
`ifdef IFQ_BYPASS_EN
    npre = 2;
`else
    npre = 1;
`endif
    mem_lat = 2;
    do_reset();
    for (int k = 0; k < 4; k++) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rp_instr_gap: got %b want 0", instr_valid);
    end
    checks++;
    if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h200}) begin
      errors++;
      $display("FAIL rp_new_req: got %b/%h want 1/00000200",
               mem_req_valid, mem_req_addr);
    end
    for (int k = 0; k < 8; k++) step();
    checks++;
    if (got_pc.size() < npre + 2) begin
      errors++;
      $display("FAIL rp_out_count: got %0d want >=%0d",
               got_pc.size(), npre + 2);
    end else begin
      checks++;
      if (got_pc[npre-1] !== 32'(4 * (npre - 1))) begin
        errors++;
        $display("FAIL rp_last_old: got %h want %h",
                 got_pc[npre-1], 32'(4 * (npre - 1)));
      end
      checks++;
      if ({got_pc[npre], got_data[npre]} !== {32'h200, dat(32'h200)}) begin
        errors++;
        $display("FAIL rp_first_new: got %h/%h want 00000200/%h",
                 got_pc[npre], got_data[npre], dat(32'h200));
      end
      checks++;
      if (got_pc[npre+1] !== 32'h204) begin
        errors++;
        $display("FAIL rp_second_new: got %h want 00000204", got_pc[npre+1]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFFC;
    exp_pc[1] = 32'h0000_0000;
    exp_pc[2] = 32'h0000_0004;
    mem_lat = 1;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL wrap_req0: got %b/%h want 1/fffffffc",
               mem_req_valid, mem_req_addr);
    end
    step();
    @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL wrap_req1: got %b/%h want 1/00000000",
               mem_req_valid, mem_req_addr);
    end
    for (int k = 0; k < 5; k++) step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_pc.size()) begin
        errors++;
        $display("FAIL wrap_seq[%0d]: missing want %h", i, exp_pc[i]);
      end else if ({got_pc[i], got_data[i]} !== {exp_pc[i], dat(exp_pc[i])}) begin
        errors++;
        $display("FAIL wrap_seq[%0d]: got %h/%h want %h/%h", i,
                 got_pc[i], got_data[i], exp_pc[i], dat(exp_pc[i]));
      end
    end
  endtask

  task automatic test_latency();
    mem_lat = 1;
    do_reset();
    step();
    @(negedge clk);
`ifdef IFQ_BYPASS_EN
    checks++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'h0, dat(32'h0)}) begin
      errors++;
      $display("FAIL byp_same_cycle: got %b/%h/%h want 1/0/%h",
               instr_valid, instr_pc, instr_data, dat(32'h0));
    end
    step();
    @(negedge clk);
    checks++;
    if ({instr_valid, instr_pc} !== {1'b1, 32'h4}) begin
      errors++;
      $display("FAIL byp_no_write: got %b/%h want 1/00000004",
               instr_valid, instr_pc);
    end
`else
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_rsp_cycle: got %b want 0", instr_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'h0, dat(32'h0)}) begin
      errors++;
      $display("FAIL lat_next_cycle: got %b/%h/%h want 1/0/%h",
               instr_valid, instr_pc, instr_data, dat(32'h0));
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_pop();
    test_wrap();
    test_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
